// File: rtl/solve_ctrl.sv
// Solver sequencer: drives the cube/network handshakes, counts applied moves and times out stalled handshakes.
// Optional move history (16x4, readable via hist_addr) is built when SOLVE_CTRL_HIST_EN is defined.
module solve_ctrl #(
  parameter int MAX_STEPS = 10,
  parameter int WAIT_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       cube_store,
  output logic       cube_load,
  input  logic       cube_valid,
  input  logic       cube_fin,
  output logic       net_load,
  input  logic       net_valid,
  input  logic [3:0] net_move,
  output logic [3:0] move,
  output logic [3:0] step,
  output logic [2:0] state,
  output logic       done,
  output logic       fail,
  input  logic [3:0] hist_addr,
  output logic [3:0] hist_data
);

  // state | meaning
  // IDLE    | waiting for run after reset
  // STORE   | cube loading its initial state
  // NETWORK | waiting for the next move from the network
  // CUBE    | cube applying the registered move
  // FINISH  | result (done/fail) held until the next run
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] STORE   = 3'd1;
  localparam logic [2:0] NETWORK = 3'd2;
  localparam logic [2:0] CUBE    = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  localparam logic [3:0] STEP_LAST = 4'(MAX_STEPS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] wdog;
  logic       wdog_hit;

  // Timeout lands exactly WAIT_MAX cycles after entering a waiting state.
  assign wdog_hit = (wdog == WAIT_LAST);

  assign cube_store = (state == STORE);
  assign net_load   = (state == NETWORK);
  assign cube_load  = (state == CUBE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 4'd0;
      move  <= 4'd0;
      done  <= 1'b0;
      fail  <= 1'b0;
      wdog  <= 8'd0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (run) begin
            state <= STORE;
            step  <= 4'd0;
            move  <= 4'd0;
            done  <= 1'b0;
            fail  <= 1'b0;
            wdog  <= 8'd0;
          end
        end
        STORE: begin
          if (cube_valid) begin
            wdog <= 8'd0;
            if (cube_fin) begin
              state <= FINISH;
              done  <= 1'b1;
              step  <= 4'd0;
            end else begin
              state <= NETWORK;
            end
          end else if (wdog_hit) begin
            state <= FINISH;
            fail  <= 1'b1;
            wdog  <= 8'd0;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        NETWORK: begin
          if (net_valid) begin
            move  <= net_move;
            state <= CUBE;
            wdog  <= 8'd0;
          end else if (wdog_hit) begin
            state <= FINISH;
            fail  <= 1'b1;
            wdog  <= 8'd0;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        CUBE: begin
          if (cube_valid) begin
            step <= step + 4'd1;
            wdog <= 8'd0;
            // A solved cube wins over budget exhaustion on the same completion.
            if (cube_fin) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (step == STEP_LAST) begin
              state <= FINISH;
              fail  <= 1'b1;
            end else begin
              state <= NETWORK;
            end
          end else if (wdog_hit) begin
            state <= FINISH;
            fail  <= 1'b1;
            wdog  <= 8'd0;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          wdog  <= 8'd0;
        end
      endcase
    end
  end

`ifdef SOLVE_CTRL_HIST_EN
  logic [3:0] hist_mem [16];

  always_ff @(posedge clk) begin
    if (rst_n && (state == CUBE) && cube_valid) begin
      hist_mem[step] <= move;
    end
  end

  assign hist_data = hist_mem[hist_addr];
`else
  logic unused_hist_addr;

  assign unused_hist_addr = ^hist_addr;
  assign hist_data        = 4'd0;
`endif

endmodule

// File: tb/tb_solve_ctrl.sv
// Directed bench for solve_ctrl (MAX_STEPS=10, WAIT_MAX=20); history checks follow SOLVE_CTRL_HIST_EN.
module tb_solve_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, run, cube_valid, cube_fin, net_valid;
  logic [3:0] net_move, hist_addr;
  logic       cube_store, cube_load, net_load, done, fail;
  logic [3:0] move, step, hist_data;
  logic [2:0] state;
  int         tests = 0;
  int         fails = 0;

  solve_ctrl #(.MAX_STEPS(10), .WAIT_MAX(20)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .cube_store(cube_store), .cube_load(cube_load),
    .cube_valid(cube_valid), .cube_fin(cube_fin),
    .net_load(net_load), .net_valid(net_valid), .net_move(net_move),
    .move(move), .step(step), .state(state), .done(done), .fail(fail),
    .hist_addr(hist_addr), .hist_data(hist_data)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; cube_valid = 1'b0; cube_fin = 1'b0;
    net_valid = 1'b0; net_move = 4'd0; hist_addr = 4'd0;
    tick(); tick();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if ({cube_store, net_load, cube_load} !== 3'b000) begin fails++; $display("FAIL reset_req: got %b want 000", {cube_store, net_load, cube_load}); end
    tests++; if ({done, fail, step, move} !== 10'd0) begin fails++; $display("FAIL reset_outs: done=%0d fail=%0d step=%0d move=%0d want all 0", done, fail, step, move); end
    rst_n = 1'b1;
    tick();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_direct_solve();
    logic saw_net = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    tests++; if (state !== 3'd1 || cube_store !== 1'b1) begin fails++; $display("FAIL run_latency: state=%0d cube_store=%0d want 1/1", state, cube_store); end
    saw_net |= net_load;
    tick();
    saw_net |= net_load;
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL store_wait: got %0d want 1", state); end
    cube_valid = 1'b1; cube_fin = 1'b1;
    tick();
    cube_valid = 1'b0; cube_fin = 1'b0;
    saw_net |= net_load;
    tests++; if (state !== 3'd4 || done !== 1'b1 || fail !== 1'b0 || step !== 4'd0) begin fails++; $display("FAIL direct_solve: state=%0d done=%0d fail=%0d step=%0d want 4/1/0/0", state, done, fail, step); end
    tests++; if (saw_net !== 1'b0) begin fails++; $display("FAIL direct_no_net: net_load seen=%0d want 0", saw_net); end
  endtask

  task automatic test_three_moves();
    logic [3:0] mv [3];
    mv[0] = 4'd3; mv[1] = 4'd7; mv[2] = 4'd5;
    run = 1'b1;
    tick();
    run = 1'b0;
    tests++; if (state !== 3'd1 || done !== 1'b0) begin fails++; $display("FAIL rerun_clear: state=%0d done=%0d want 1/0", state, done); end
    cube_valid = 1'b1;
    tick();
    cube_valid = 1'b0;
    tests++; if (state !== 3'd2 || net_load !== 1'b1) begin fails++; $display("FAIL to_network: state=%0d net_load=%0d want 2/1", state, net_load); end
    for (int i = 0; i < 3; i++) begin
      // Stray cube handshake and run while waiting on the network must be ignored.
      cube_valid = 1'b1; cube_fin = 1'b1; run = 1'b1;
      tick();
      cube_valid = 1'b0; cube_fin = 1'b0; run = 1'b0;
      tests++; if (state !== 3'd2 || done !== 1'b0) begin fails++; $display("FAIL stray_in_net[%0d]: state=%0d done=%0d want 2/0", i, state, done); end
      net_valid = 1'b1; net_move = mv[i];
      tick();
      net_valid = 1'b0; net_move = 4'hf;
      tests++; if (state !== 3'd3 || cube_load !== 1'b1 || move !== mv[i]) begin fails++; $display("FAIL net_capture[%0d]: state=%0d cube_load=%0d move=%0d want 3/1/%0d", i, state, cube_load, move, mv[i]); end
      cube_valid = 1'b1; cube_fin = (i == 2);
      tick();
      cube_valid = 1'b0; cube_fin = 1'b0;
      tests++; if (step !== 4'(i + 1) || state !== ((i == 2) ? 3'd4 : 3'd2)) begin fails++; $display("FAIL cube_step[%0d]: step=%0d state=%0d want %0d/%0d", i, step, state, i + 1, (i == 2) ? 4 : 2); end
    end
    tests++; if (done !== 1'b1 || fail !== 1'b0 || step !== 4'd3) begin fails++; $display("FAIL three_result: done=%0d fail=%0d step=%0d want 1/0/3", done, fail, step); end
    for (int i = 0; i < 3; i++) begin
      hist_addr = 4'(i);
      #1;
`ifdef SOLVE_CTRL_HIST_EN
      tests++; if (hist_data !== mv[i]) begin fails++; $display("FAIL hist[%0d]: got %0d want %0d", i, hist_data, mv[i]); end
`else
      tests++; if (hist_data !== 4'd0) begin fails++; $display("FAIL hist_off[%0d]: got %0d want 0", i, hist_data); end
`endif
    end
  endtask

  task automatic test_budget(input logic fin_last);
    run = 1'b1;
    tick();
    run = 1'b0;
    cube_valid = 1'b1;
    tick();
    cube_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      net_valid = 1'b1; net_move = 4'(i);
      tick();
      net_valid = 1'b0;
      cube_valid = 1'b1; cube_fin = fin_last && (i == 9);
      tick();
      cube_valid = 1'b0; cube_fin = 1'b0;
      if (i < 9) begin
        tests++; if (state !== 3'd2 || step !== 4'(i + 1)) begin fails++; $display("FAIL budget_step[%0d]: state=%0d step=%0d want 2/%0d", i, state, step, i + 1); end
      end
    end
    tests++; if (state !== 3'd4 || step !== 4'd10 || done !== fin_last || fail !== !fin_last) begin fails++; $display("FAIL budget_end(fin=%0d): state=%0d step=%0d done=%0d fail=%0d want 4/10/%0d/%0d", fin_last, state, step, done, fail, fin_last, !fin_last); end
  endtask

  task automatic test_watchdog();
    run = 1'b1;
    tick();
    run = 1'b0;
    cube_valid = 1'b1;
    tick();
    cube_valid = 1'b0;
    net_valid = 1'b1; net_move = 4'd2;
    tick();
    net_valid = 1'b0;
    cube_valid = 1'b1;
    tick();
    cube_valid = 1'b0;
    tests++; if (state !== 3'd2 || step !== 4'd1) begin fails++; $display("FAIL wd_entry: state=%0d step=%0d want 2/1", state, step); end
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i == 19) begin
        tests++; if (state !== 3'd2 || fail !== 1'b0) begin fails++; $display("FAIL wd_early: state=%0d fail=%0d want 2/0 at cycle 19", state, fail); end
      end
    end
    tick();
    tests++; if (state !== 3'd4 || fail !== 1'b1 || done !== 1'b0 || step !== 4'd1) begin fails++; $display("FAIL wd_expire: state=%0d fail=%0d done=%0d step=%0d want 4/1/0/1", state, fail, done, step); end
  endtask

  task automatic test_run_after_fail();
    tick();
    tests++; if (state !== 3'd4 || fail !== 1'b1) begin fails++; $display("FAIL finish_hold: state=%0d fail=%0d want 4/1", state, fail); end
    run = 1'b1;
    tick();
    run = 1'b0;
    tests++; if (state !== 3'd1 || fail !== 1'b0 || step !== 4'd0 || move !== 4'd0) begin fails++; $display("FAIL rerun_after_fail: state=%0d fail=%0d step=%0d move=%0d want 1/0/0/0", state, fail, step, move); end
  endtask

  task automatic test_reset_mid_run();
    cube_valid = 1'b1;
    tick();
    cube_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      net_valid = 1'b1; net_move = 4'(i + 8);
      tick();
      net_valid = 1'b0;
      cube_valid = 1'b1;
      tick();
      cube_valid = 1'b0;
    end
    net_valid = 1'b1; net_move = 4'd9;
    tick();
    net_valid = 1'b0;
    tests++; if (state !== 3'd3 || step !== 4'd4) begin fails++; $display("FAIL mid_setup: state=%0d step=%0d want 3/4", state, step); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (state !== 3'd0 || step !== 4'd0 || cube_load !== 1'b0 || move !== 4'd0) begin fails++; $display("FAIL mid_reset: state=%0d step=%0d cube_load=%0d move=%0d want 0/0/0/0", state, step, cube_load, move); end
    net_valid = 1'b1; net_move = 4'd6; cube_valid = 1'b1; cube_fin = 1'b1;
    tick();
    net_valid = 1'b0; cube_valid = 1'b0; cube_fin = 1'b0;
    tests++; if (state !== 3'd0 || move !== 4'd0 || done !== 1'b0) begin fails++; $display("FAIL idle_stray: state=%0d move=%0d done=%0d want 0/0/0", state, move, done); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct_solve();
    test_three_moves();
    test_budget(1'b0);
    test_budget(1'b1);
    test_watchdog();
    test_run_after_fail();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/solve_ctrl.md
SOLVE_CTRL -- requirements
Module: solve_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 10, move budget before fail (1..15).
REQ-002 SHALL have parameter WAIT_MAX, default 255, max cycles waiting on any handshake (1..255).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 run  input  1  start request, sampled in IDLE and FINISH.
REQ-007 cube_store  output  1  cube initial-state load request.
REQ-008 cube_load  output  1  cube apply-move request.
REQ-009 cube_valid  input  1  cube operation complete, one-cycle pulse.
REQ-010 cube_fin  input  1  cube solved, qualified by cube_valid.
REQ-011 net_load  output  1  network inference request.
REQ-012 net_valid  input  1  network result ready, one-cycle pulse.
REQ-013 net_move  input  4  move code from network.
REQ-014 move  output  4  registered move driven to cube.
REQ-015 step  output  4  moves applied this run.
REQ-016 state  output  3  current FSM state, debug.
REQ-017 done  output  1  solved.
REQ-018 fail  output  1  budget or watchdog exhausted.
REQ-019 hist_addr  input  4  history read index.
REQ-020 hist_data  output  4  history read data, combinational.

Function
REQ-021 FSM states SHALL be IDLE=0, STORE=1, NETWORK=2, CUBE=3, FINISH=4; other codes go to IDLE next cycle.
REQ-022 Request outputs SHALL be Moore decodes of the state register: cube_store=STORE, net_load=NETWORK, cube_load=CUBE; no combinational input-to-output path except hist_data.
REQ-023 IDLE: run=1 -> STORE next cycle; step, move, done, fail, watchdog cleared on the same edge.
REQ-024 STORE: cube_valid with cube_fin=1 -> FINISH, done=1, step=0; cube_valid with cube_fin=0 -> NETWORK.
REQ-025 NETWORK: net_valid=1 -> move<=net_move, -> CUBE.
REQ-026 CUBE: cube_valid=1 -> step<=step+1, history[step]<=move; then cube_fin=1 -> FINISH done=1; else step+1==MAX_STEPS -> FINISH fail=1; else -> NETWORK.
REQ-027 cube_fin and budget exhaustion on the same cube_valid SHALL yield done=1, fail=0.
REQ-028 Watchdog: 8-bit counter cleared on every state change, increments each cycle in STORE/NETWORK/CUBE; reaching WAIT_MAX -> FINISH fail=1, step unchanged.
REQ-029 FINISH: done/fail/step/move hold; run=1 -> STORE with clears per REQ-023.
REQ-030 cube_valid, net_valid, cube_fin outside their consuming state SHALL be ignored; run outside IDLE/FINISH ignored.
REQ-031 done and fail SHALL never be 1 simultaneously; step SHALL never exceed MAX_STEPS.
REQ-032 Latency: run sampled at edge N -> cube_store high from N+1; net_valid at edge M -> cube_load high from M+1.

Reset
REQ-033 rst_n=0 at an edge SHALL set state=IDLE, outputs move, step, done, fail, all requests to 0, watchdog 0, regardless of state (mid-run abort).
REQ-034 History contents SHALL be left unreset; reads after reset before any write are don't-care.

Configuration
REQ-035 Macro SOLVE_CTRL_HIST_EN defined: 16x4 history array written per REQ-026, hist_data=history[hist_addr].
REQ-036 Macro undefined: no array, hist_data=0, hist_addr ignored; all other behaviour identical.

Verification
REQ-037 run pulse, cube_valid+cube_fin in STORE -> FINISH, done=1, step=0, net_load never asserted.
REQ-038 run, network returns moves 3,7,5, cube_fin on third cube_valid -> done=1, step=3; with HIST_EN hist_addr 0/1/2 -> 3/7/5.
REQ-039 MAX_STEPS=10, cube_fin never -> after 10th cube_valid fail=1, step=10; 10th with cube_fin=1 -> done=1, fail=0.
REQ-040 WAIT_MAX=20, net_valid withheld in NETWORK -> FINISH fail=1 exactly 20 cycles after entry.
REQ-041 rst_n low in CUBE with step=4 -> next cycle state=0, step=0, cube_load=0; stray net_valid in IDLE -> no change.
REQ-042 run in FINISH after fail -> STORE next cycle, fail=0, step=0.
